// File: rtl/mitchell_mul_pipe.sv
// Three-stage pipelined signed Mitchell log multiplier with valid/ready flow control and tag passthrough.
// Optional log-domain debug outputs (out_ka, out_kb, out_ksum, out_mant) when MITCHELL_DBG_EN is defined.
module mitchell_mul_pipe #(
    parameter int WIDTH = 9,
    parameter int TAG_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   in_x,
    input  logic signed [WIDTH-1:0]   in_y,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]          out_tag
`ifdef MITCHELL_DBG_EN
    ,
    output logic [$clog2(WIDTH)-1:0]   out_ka,
    output logic [$clog2(WIDTH)-1:0]   out_kb,
    output logic [$clog2(2*WIDTH)-1:0] out_ksum,
    output logic [WIDTH-1:0]           out_mant
`endif
);

    localparam int KW  = $clog2(WIDTH);
    localparam int KSW = $clog2(2*WIDTH);
    localparam int FW  = WIDTH - 1;
    localparam int OW  = 2 * WIDTH;
    localparam int PW  = 3 * WIDTH;

    // Handshake: a transfer happens on a rising edge where valid && ready. The
    // whole pipe freezes only when the output holds a result nobody takes, so
    // in_ready is simply the inverse of that stall condition.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    function automatic logic [KW-1:0] lod(input logic [WIDTH-1:0] m);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) k = KW'(i);
        end
        return k;
    endfunction

    function automatic logic [FW-1:0] frac(input logic [WIDTH-1:0] m, input logic [KW-1:0] k);
        // Normalise so the leading one sits at the MSB, then drop it.
        return FW'(m << (KW'(FW) - k));
    endfunction

    // Stage 1 combinational: sign, magnitudes, leading-one positions, fractions
    logic [WIDTH-1:0] ma, mb;
    logic [KW-1:0]    ka, kb;
    logic [FW-1:0]    fa, fb;
    logic             sign_c, zero_c;

    always_comb begin
        ma     = in_x[WIDTH-1] ? WIDTH'(-in_x) : WIDTH'(in_x);
        mb     = in_y[WIDTH-1] ? WIDTH'(-in_y) : WIDTH'(in_y);
        ka     = lod(ma);
        kb     = lod(mb);
        fa     = frac(ma, ka);
        fb     = frac(mb, kb);
        sign_c = in_x[WIDTH-1] ^ in_y[WIDTH-1];
        zero_c = (ma == '0) || (mb == '0);
    end

    logic             s1_valid, s1_sign, s1_zero;
    logic [KW-1:0]    s1_ka, s1_kb;
    logic [FW-1:0]    s1_fa, s1_fb;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2 combinational: add in the log domain
    logic             carry;
    logic [FW-1:0]    fsum;
    logic [KSW-1:0]   ksum_c;
    logic [WIDTH-1:0] mant_c;

    always_comb begin
        {carry, fsum} = {1'b0, s1_fa} + {1'b0, s1_fb};
        ksum_c        = KSW'(s1_ka) + KSW'(s1_kb) + KSW'(carry);
        // A carry means the fraction sum crossed 1.0: bump the exponent and
        // keep the overflowed bits as the new fraction under the implicit one.
        mant_c        = {1'b1, fsum};
    end

    logic             s2_valid, s2_sign, s2_zero;
    logic [KSW-1:0]   s2_ksum;
    logic [WIDTH-1:0] s2_mant;
    logic [TAG_W-1:0] s2_tag;

    // Stage 3 combinational: antilog by shifting, then apply sign
    logic [OW-1:0]        mag;
    logic signed [OW-1:0] prod;

    always_comb begin
        mag  = OW'((PW'(s2_mant) << s2_ksum) >> FW);
        prod = s2_zero ? '0 : (s2_sign ? -mag : mag);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_ka     <= '0;
            s1_kb     <= '0;
            s1_fa     <= '0;
            s1_fb     <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_ksum   <= '0;
            s2_mant   <= '0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_sign   <= sign_c;
            s1_zero   <= zero_c;
            s1_ka     <= ka;
            s1_kb     <= kb;
            s1_fa     <= fa;
            s1_fb     <= fb;
            s1_tag    <= in_tag;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_zero   <= s1_zero;
            s2_ksum   <= ksum_c;
            s2_mant   <= mant_c;
            s2_tag    <= s1_tag;
            out_valid <= s2_valid;
            out_p     <= prod;
            out_tag   <= s2_tag;
        end
    end

`ifdef MITCHELL_DBG_EN
    logic [KW-1:0] s2_ka, s2_kb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_ka    <= '0;
            s2_kb    <= '0;
            out_ka   <= '0;
            out_kb   <= '0;
            out_ksum <= '0;
            out_mant <= '0;
        end else if (!stall) begin
            s2_ka    <= s1_ka;
            s2_kb    <= s1_kb;
            out_ka   <= s2_ka;
            out_kb   <= s2_kb;
            out_ksum <= s2_ksum;
            out_mant <= s2_mant;
        end
    end
`endif

endmodule

// File: tb/tb_mitchell_mul_pipe.sv
// Self-checking bench for mitchell_mul_pipe: vector table, streaming, stall, reset and random traffic.
module tb_mitchell_mul_pipe;

    localparam int W  = 9;
    localparam int TW = 4;
    localparam int OW = 2 * W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_x;
    logic signed [W-1:0]  in_y;
    logic [TW-1:0]        in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_p;
    logic [TW-1:0]        out_tag;
`ifdef MITCHELL_DBG_EN
    logic [$clog2(W)-1:0]   dbg_ka, dbg_kb;
    logic [$clog2(2*W)-1:0] dbg_ksum;
    logic [W-1:0]           dbg_mant;
`endif

    mitchell_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
`ifdef MITCHELL_DBG_EN
        ,
        .out_ka    (dbg_ka),
        .out_kb    (dbg_kb),
        .out_ksum  (dbg_ksum),
        .out_mant  (dbg_mant)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [OW+TW-1:0]     exp_q[$];
    logic signed [OW-1:0] cur_exp;

    typedef struct {
        logic signed [W-1:0]  x;
        logic signed [W-1:0]  y;
        logic [TW-1:0]        tag;
        logic signed [OW-1:0] p;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: scaled-integer Mitchell approximation, fractions in units of 2^-(W-1)
    function automatic logic signed [OW-1:0] model(input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] y);
        int ax, ay, ka, kb, fa, fb, s;
        longint m;
        ax = (x < 0) ? -int'(x) : int'(x);
        ay = (y < 0) ? -int'(y) : int'(y);
        if (ax == 0 || ay == 0) return '0;
        ka = 0;
        while ((1 << (ka + 1)) <= ax) ka++;
        kb = 0;
        while ((1 << (kb + 1)) <= ay) kb++;
        fa = (ax - (1 << ka)) << (W - 1 - ka);
        fb = (ay - (1 << kb)) << (W - 1 - kb);
        s  = fa + fb;
        if (s < (1 << (W - 1)))
            m = (longint'((1 << (W - 1)) + s) << (ka + kb)) >> (W - 1);
        else
            m = (longint'(s) << (ka + kb + 1)) >> (W - 1);
        if ((x < 0) != (y < 0)) m = -m;
        return OW'(m);
    endfunction

    function automatic logic signed [W-1:0] pick_operand();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return W'(-256);
        if (r == 1) return '0;
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        logic [OW+TW-1:0] e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_p", out_p, $signed(e[OW-1:0]));
                    check("out_tag", out_tag, e[OW+:TW]);
                end
            end
            if (in_valid && in_ready) exp_q.push_back({in_tag, cur_exp});
        end
    end

    task automatic send(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                        input logic [TW-1:0] t, input logic signed [OW-1:0] e);
        int b;
        in_x     = x;
        in_y     = y;
        in_tag   = t;
        cur_exp  = e;
        in_valid = 1'b1;
        b = 0;
        @(negedge clk);
        while (!in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 50) begin
            @(negedge clk);
            b++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{5, 3, 1, 14};
        vecs[1]  = '{15, 5, 2, 72};
        vecs[2]  = '{20, 4, 3, 80};
        vecs[3]  = '{-27, 119, 4, -3168};
        vecs[4]  = '{-256, -256, 5, 65536};
        vecs[5]  = '{0, 18, 6, 0};
        vecs[6]  = '{-1, -1, 7, 1};
        vecs[7]  = '{1, -1, 8, -1};
        vecs[8]  = '{-5, 3, 9, -14};
        vecs[9]  = '{255, 255, 10, 65024};
        vecs[10] = '{-256, 255, 11, -65280};
        vecs[11] = '{0, -256, 12, 0};

        // Clock/reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_p", out_p, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table, one operation at a time, with latency check
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].tag, vecs[i].p);
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("latency", n, 3);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        drain("table_drain");

        // Back-to-back stream of 10 with tags 0..9
        fork
            begin
                logic signed [W-1:0] sx, sy;
                for (int i = 0; i < 10; i++) begin
                    sx = pick_operand();
                    sy = pick_operand();
                    send(sx, sy, TW'(i), model(sx, sy));
                end
                in_valid = 1'b0;
            end
            begin
                int b;
                b = 0;
                @(negedge clk);
                while (!out_valid && b < 20) begin
                    @(negedge clk);
                    b++;
                end
                check("stream_start", out_valid, 1);
                for (int i = 1; i < 10; i++) begin
                    @(negedge clk);
                    check("stream_consecutive", out_valid, 1);
                end
            end
        join
        drain("stream_drain");
        @(posedge clk);
        #1;

        // Stall with three operations in flight
        out_ready = 1'b1;
        send(5, 3, 4'hA, 14);
        send(15, 5, 4'hB, 72);
        send(-27, 119, 4'hC, -3168);
        out_ready = 1'b0;
        in_x      = 7;
        in_y      = 9;
        in_tag    = 4'hD;
        cur_exp   = model(7, 9);
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_p", out_p, 14);
            check("stall_out_tag", out_tag, 4'hA);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("stall_drain");
        repeat (4) @(negedge clk);

        // Reset with three operations in flight
        @(posedge clk);
        #1;
        send(20, 4, 4'h1, 80);
        send(-5, 3, 4'h2, -14);
        send(255, 255, 4'h3, 65024);
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_out_tag", out_tag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_in_ready", in_ready, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_no_output", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure
        for (int i = 0; i < 80; i++) begin
            logic signed [W-1:0] rx, ry;
            rx        = pick_operand();
            ry        = pick_operand();
            in_x      = rx;
            in_y      = ry;
            in_tag    = TW'($urandom_range(0, 15));
            cur_exp   = model(rx, ry);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("random_drain");
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mitchell_mul_pipe.md
Name: mitchell_mul_pipe

Overview:
- Parametrised, pipelined successor to the combinational signed Mitchell log multiplier.
- Computes an approximate signed product of two WIDTH-bit two's-complement operands using Mitchell's log/antilog approximation.
- Three register stages with valid/ready flow control and a passthrough tag.
- Sits in the approximate-arithmetic datapath, feeding accumulators that may stall.

Parameters:
- WIDTH, 9, operand width in bits, signed, two's complement, minimum 4.
- TAG_W, 4, sideband tag width carried alongside each operation.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operand pair presented.
- in_ready, output, 1, block accepts operands this cycle.
- in_x, input, WIDTH, signed operand x.
- in_y, input, WIDTH, signed operand y.
- in_tag, input, TAG_W, opaque tag.
- out_valid, output, 1, product valid.
- out_ready, input, 1, downstream accepts the product.
- out_p, output, 2*WIDTH, signed approximate product.
- out_tag, output, TAG_W, tag of the product on out_p.

Behaviour:
- Reset: all stage valid bits = 0, out_valid = 0, out_p = 0, out_tag = 0. Reset clears in-flight operations with no output.
- Transfer occurs on (valid && ready) at a rising edge.
- stall = out_valid && !out_ready.
- in_ready = !stall, combinational from registered out_valid and out_ready.
- While stall is high, every stage holds its data and valid.
- Otherwise all stages advance together. Bubbles advance as valid=0.
- Latency: 3 cycles from input transfer to out_valid. Throughput: 1 per cycle when out_ready stays high.
- Stage 1 (sign/LOD):
  - sign = x[MSB] ^ y[MSB].
  - Magnitudes Ma = |x| and Mb = |y|, each WIDTH bits unsigned, so -2^(WIDTH-1) yields 2^(WIDTH-1).
  - zero = (Ma==0) || (Mb==0).
  - Leading-one positions kA, kB, each clog2(WIDTH) bits.
  - Fractions fA = (Ma << (WIDTH-1-kA)) with the leading one dropped, kept as WIDTH-1 fraction bits. fB is formed the same way.
- Stage 2 (log add):
  - ksum = kA + kB, width clog2(2*WIDTH).
  - {c, fsum} = fA + fB, where c is the carry out of WIDTH-1 bits.
  - If c = 1: ksum = ksum + 1 and mant = {1, fsum} (fsum is the low bits). If c = 0: mant = {1, fsum}.
- Stage 3 (antilog/sign):
  - mag = mant shifted left by ksum, then right by WIDTH-1, truncating any discarded bits.
  - The result is always at most the exact |x*y|.
  - out_p = zero ? 0 : (sign ? -mag : mag), sign-extended to 2*WIDTH bits.
  - A zero result is never negative.
- Width rule: 2*WIDTH bits holds (-2^(WIDTH-1))^2 exactly. No saturation is needed.
- out_tag travels with its operation unchanged.
- Reset asserted mid-stall drops all pending results. in_ready = 1 on the first cycle after release.

Optional Feature:
- Macro: MITCHELL_DBG_EN.
- Defined:
  - Adds output ports out_ka and out_kb (clog2(WIDTH) each), out_ksum (clog2(2*WIDTH)) and out_mant (WIDTH).
  - Registered alongside out_p, valid when out_valid = 1, reset to 0.
  - Used for observing the log-domain internals.
- Undefined: ports absent, debug registers not synthesised, product behaviour identical.

Test Plan:
- WIDTH=9, x=5, y=3, out_ready=1 -> out_p=14 exactly 3 cycles after transfer; tag echoed.
- x=15, y=5 (fraction carry) -> out_p=72. x=20, y=4 (power of two) -> out_p=80 exact.
- x=-27, y=119 -> out_p=-3168 (exact -3213). x=-256, y=-256 -> out_p=65536. x=0, y=18 -> out_p=0.
- Back-to-back stream of 10 pairs with tags 0..9 and out_ready=1 -> 10 results on consecutive cycles, in order, tags matched.
- Hold out_ready=0 for 5 cycles with 3 operations in flight -> in_ready=0 while stalled, out_p/out_tag stable, no loss or duplication after release.
- Assert rst for 1 cycle with 3 operations in flight -> out_valid=0, out_p=0 immediately; no stale results after release.
